// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, the NOP
// instruction word and a saturating counter helper.
package pipeline_sequencer_pkg;

    // Sequencer phases. The 2-bit encoding is shared with the debug/status logic.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_e;

    // Instruction word that a flushed IF/ID register holds.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Width of the load-use stall statistics counter.
    localparam int unsigned STALL_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] val);
        logic [STALL_CNT_W-1:0] res;
        res = (val == {STALL_CNT_W{1'b1}}) ? val : val + 1'b1;
        return res;
    endfunction

endpackage : pipeline_sequencer_pkg

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use hazard compare between the EX-stage load destination and the
// ID-stage source registers. Purely combinational; register 0 is compared
// like any other id.
module pipeline_sequencer_hazard_detect #(
    parameter int unsigned REG_W = 4
) (
    input  logic [REG_W-1:0] rs_a_i,
    input  logic [REG_W-1:0] rs_b_i,
    input  logic             uses_b_i,
    input  logic             mem_read_ex_i,
    input  logic [REG_W-1:0] rd_ex_i,
    output logic             load_use_o
);

    logic match_a;
    logic match_b;

    // Source B only counts when the ID instruction actually reads it.
    always_comb begin
        match_a    = (rd_ex_i == rs_a_i);
        match_b    = uses_b_i && (rd_ex_i == rs_b_i);
        load_use_o = mem_read_ex_i && (match_a || match_b);
    end

endmodule : pipeline_sequencer_hazard_detect

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: streams the boot program into instruction memory, then
// issues per-cycle PC enable / IF-ID hold / flush controls for load-use stalls,
// taken branches and the halt drain.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_BOOT  | bios streams the program; write enable toggles per word
//  ST_RUN   | normal issue; branch > load-use stall > halt priority
//  ST_DRAIN | halt accepted; wait for in-flight instructions to retire
//  ST_HALT  | pipeline frozen with both flushes asserted; reset exits
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned BOOT_LEN = 6,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned DRAIN    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_W-1:0]  rsA,
    input  logic [REG_W-1:0]  rsB,
    input  logic              usesB,
    input  logic              haltReq,
    input  logic              memRead_id_ex,
    input  logic [REG_W-1:0]  registerFileWrite_id_ex,
    input  logic              branchResult,
    output logic              onBios,
    output logic [ADDR_W-1:0] bootAddress,
    output logic              bootWE,
    output logic              resetRegisterFile,
    output logic              enablePC,
    output logic              ifIdWrite,
    output logic              ifIdFlush,
    output logic              idExFlush,
    output logic              halted,
    output logic [15:0]       stallCount
);

    // One boot cycle per write-high phase plus one per low phase.
    localparam int unsigned BOOT_CYCLES = 2 * BOOT_LEN;
    localparam int unsigned BOOT_CNT_W  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned DRAIN_CNT_W = $clog2(DRAIN + 1);

    localparam logic [BOOT_CNT_W-1:0]  BOOT_LAST  = BOOT_CNT_W'(BOOT_CYCLES - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);

    seq_state_e             state_q, state_d;
    logic [BOOT_CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [ADDR_W-1:0]      boot_addr_q, boot_addr_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   load_use;

    pipeline_sequencer_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .rs_a_i        (rsA),
        .rs_b_i        (rsB),
        .uses_b_i      (usesB),
        .mem_read_ex_i (memRead_id_ex),
        .rd_ex_i       (registerFileWrite_id_ex),
        .load_use_o    (load_use)
    );

    assign bootAddress = boot_addr_q;
    assign stallCount  = stall_cnt_q;

    // State and counter registers; reset from any state restarts boot at address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= '0;
            boot_addr_q <= '0;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            boot_addr_q <= boot_addr_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state and per-cycle pipeline controls.
    always_comb begin
        state_d           = state_q;
        boot_cnt_d        = boot_cnt_q;
        boot_addr_d       = boot_addr_q;
        drain_cnt_d       = drain_cnt_q;
        stall_cnt_d       = stall_cnt_q;
        onBios            = 1'b0;
        bootWE            = 1'b0;
        resetRegisterFile = 1'b0;
        enablePC          = 1'b0;
        ifIdWrite         = 1'b0;
        ifIdFlush         = 1'b0;
        idExFlush         = 1'b0;
        halted            = 1'b0;

        unique case (state_q)
            ST_BOOT: begin
                onBios            = 1'b1;
                resetRegisterFile = 1'b1;
                ifIdFlush         = 1'b1;
                idExFlush         = 1'b1;
                // No memory writes while reset is held; even boot cycles write.
                bootWE            = ~boot_cnt_q[0] & ~reset;
                boot_cnt_d        = boot_cnt_q + 1'b1;
                if (boot_cnt_q[0]) begin
                    boot_addr_d = boot_addr_q + 1'b1;
                end
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (branchResult) begin
                    enablePC  = 1'b1;
                    ifIdWrite = 1'b1;
                    ifIdFlush = 1'b1;
                    idExFlush = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, inject one bubble into ID/EX.
                    idExFlush   = 1'b1;
                    stall_cnt_d = sat_inc(stall_cnt_q);
                end else if (haltReq) begin
                    // HALT itself proceeds to EX; nothing younger is fetched.
                    ifIdWrite   = 1'b1;
                    ifIdFlush   = 1'b1;
                    drain_cnt_d = DRAIN_LOAD;
                    state_d     = ST_DRAIN;
                end else begin
                    enablePC  = 1'b1;
                    ifIdWrite = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Branches are ignored here: a halt is never cancelled.
                ifIdFlush   = 1'b1;
                idExFlush   = 1'b1;
                drain_cnt_d = drain_cnt_q - 1'b1;
                if (drain_cnt_q == DRAIN_ONE) begin
                    state_d = ST_HALT;
                end
            end

            ST_HALT: begin
                halted    = 1'b1;
                ifIdFlush = 1'b1;
                idExFlush = 1'b1;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule : pipeline_sequencer

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with hand-computed expectations.
module tb_pipeline_sequencer;

    localparam int unsigned BOOT_LEN = 6;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned DRAIN    = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [REG_W-1:0]  rsA;
    logic [REG_W-1:0]  rsB;
    logic              usesB;
    logic              haltReq;
    logic              memRead_id_ex;
    logic [REG_W-1:0]  registerFileWrite_id_ex;
    logic              branchResult;
    logic              onBios;
    logic [ADDR_W-1:0] bootAddress;
    logic              bootWE;
    logic              resetRegisterFile;
    logic              enablePC;
    logic              ifIdWrite;
    logic              ifIdFlush;
    logic              idExFlush;
    logic              halted;
    logic [15:0]       stallCount;

    int checks = 0;
    int errors = 0;
    int we_pulses;

    pipeline_sequencer #(
        .BOOT_LEN (BOOT_LEN),
        .ADDR_W   (ADDR_W),
        .REG_W    (REG_W),
        .DRAIN    (DRAIN)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .rsA                     (rsA),
        .rsB                     (rsB),
        .usesB                   (usesB),
        .haltReq                 (haltReq),
        .memRead_id_ex           (memRead_id_ex),
        .registerFileWrite_id_ex (registerFileWrite_id_ex),
        .branchResult            (branchResult),
        .onBios                  (onBios),
        .bootAddress             (bootAddress),
        .bootWE                  (bootWE),
        .resetRegisterFile       (resetRegisterFile),
        .enablePC                (enablePC),
        .ifIdWrite               (ifIdWrite),
        .ifIdFlush               (ifIdFlush),
        .idExFlush               (idExFlush),
        .halted                  (halted),
        .stallCount              (stallCount)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        rsA = '0; rsB = '0; usesB = 1'b0; haltReq = 1'b0;
        memRead_id_ex = 1'b0; registerFileWrite_id_ex = '0; branchResult = 1'b0;
    endtask

    // Release reset and walk the 12 boot cycles, checking the write stream.
    task automatic run_boot();
        reset = 1'b0;
        we_pulses = 0;
        #1;
        for (int c = 0; c < 2 * BOOT_LEN; c++) begin
            check($sformatf("boot_we_c%0d", c), {31'd0, bootWE}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("boot_addr_c%0d", c), bootAddress, 32'(c / 2));
            check("boot_onbios", {31'd0, onBios}, 32'd1);
            check("boot_enpc", {31'd0, enablePC}, 32'd0);
            if (bootWE === 1'b1) we_pulses++;
            tick();
        end
        check("boot_we_pulses", 32'(we_pulses), 32'd6);
        check("run_onbios", {31'd0, onBios}, 32'd0);
        check("run_rrf", {31'd0, resetRegisterFile}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        // Reset condition (reset still held)
        check("rst_onbios", {31'd0, onBios}, 32'd1);
        check("rst_addr", bootAddress, 32'd0);
        check("rst_we", {31'd0, bootWE}, 32'd0);
        check("rst_rrf", {31'd0, resetRegisterFile}, 32'd1);
        check("rst_enpc", {31'd0, enablePC}, 32'd0);
        check("rst_ifidw", {31'd0, ifIdWrite}, 32'd0);
        check("rst_ifidf", {31'd0, ifIdFlush}, 32'd1);
        check("rst_idexf", {31'd0, idExFlush}, 32'd1);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_stall", {16'd0, stallCount}, 32'd0);

        // 1. boot stream
        run_boot();
        check("run_idle_enpc", {31'd0, enablePC}, 32'd1);
        check("run_idle_ifidw", {31'd0, ifIdWrite}, 32'd1);
        check("run_idle_idexf", {31'd0, idExFlush}, 32'd0);

        // 2. load r3 in EX, ID add r1 = r3 + r2
        memRead_id_ex = 1'b1; registerFileWrite_id_ex = 4'd3;
        rsA = 4'd3; rsB = 4'd2; usesB = 1'b1;
        #1;
        check("lu_enpc", {31'd0, enablePC}, 32'd0);
        check("lu_ifidw", {31'd0, ifIdWrite}, 32'd0);
        check("lu_idexf", {31'd0, idExFlush}, 32'd1);
        check("lu_ifidf", {31'd0, ifIdFlush}, 32'd0);
        tick();
        memRead_id_ex = 1'b0;  // bubble now in EX
        #1;
        check("lu_after_enpc", {31'd0, enablePC}, 32'd1);
        check("lu_stall_cnt", {16'd0, stallCount}, 32'd1);

        // 3. load r5, rsB=5 but not used -> no stall; used -> stall
        memRead_id_ex = 1'b1; registerFileWrite_id_ex = 4'd5;
        rsA = 4'd1; rsB = 4'd5; usesB = 1'b0;
        #1;
        check("nob_enpc", {31'd0, enablePC}, 32'd1);
        check("nob_idexf", {31'd0, idExFlush}, 32'd0);
        tick();
        check("nob_stall_cnt", {16'd0, stallCount}, 32'd1);
        usesB = 1'b1;
        #1;
        check("useb_enpc", {31'd0, enablePC}, 32'd0);
        check("useb_ifidw", {31'd0, ifIdWrite}, 32'd0);
        tick();
        check("useb_stall_cnt", {16'd0, stallCount}, 32'd2);
        // register 0 compared like any other
        registerFileWrite_id_ex = 4'd0; rsA = 4'd0; rsB = 4'd7;
        #1;
        check("r0_enpc", {31'd0, enablePC}, 32'd0);
        tick();
        check("r0_stall_cnt", {16'd0, stallCount}, 32'd3);

        // 4. branch + load-use + halt in the same cycle: branch wins
        registerFileWrite_id_ex = 4'd3; rsA = 4'd3; branchResult = 1'b1; haltReq = 1'b1;
        #1;
        check("br_enpc", {31'd0, enablePC}, 32'd1);
        check("br_ifidf", {31'd0, ifIdFlush}, 32'd1);
        check("br_idexf", {31'd0, idExFlush}, 32'd1);
        check("br_ifidw", {31'd0, ifIdWrite}, 32'd1);
        tick();
        clear_inputs();
        #1;
        check("br_stall_cnt", {16'd0, stallCount}, 32'd3);
        check("br_still_run", {31'd0, enablePC}, 32'd1);

        // 5. halt -> 3 drain cycles (branch ignored) -> halted
        haltReq = 1'b1;
        #1;
        check("hreq_enpc", {31'd0, enablePC}, 32'd0);
        check("hreq_ifidf", {31'd0, ifIdFlush}, 32'd1);
        tick();
        haltReq = 1'b0; branchResult = 1'b1;
        for (int i = 0; i < DRAIN; i++) begin
            #1;
            check($sformatf("drain%0d_enpc", i), {31'd0, enablePC}, 32'd0);
            check($sformatf("drain%0d_flush", i), {30'd0, ifIdFlush, idExFlush}, 32'd3);
            check($sformatf("drain%0d_halted", i), {31'd0, halted}, 32'd0);
            tick();
        end
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_enpc", {31'd0, enablePC}, 32'd0);
        tick();
        tick();
        check("halt_sticky", {31'd0, halted}, 32'd1);
        check("halt_flush", {30'd0, ifIdFlush, idExFlush}, 32'd3);
        clear_inputs();

        // 6a. reset during DRAIN
        reset = 1'b1;
        tick();
        run_boot();
        memRead_id_ex = 1'b1; registerFileWrite_id_ex = 4'd9; rsA = 4'd9;
        tick();
        clear_inputs();
        #1;
        check("r6_stall_pre", {16'd0, stallCount}, 32'd1);
        haltReq = 1'b1;
        tick();
        haltReq = 1'b0;
        #1;
        check("r6_in_drain", {30'd0, ifIdFlush, idExFlush}, 32'd3);
        reset = 1'b1;
        tick();
        check("rdrain_onbios", {31'd0, onBios}, 32'd1);
        check("rdrain_addr", bootAddress, 32'd0);
        check("rdrain_stall", {16'd0, stallCount}, 32'd0);
        check("rdrain_halted", {31'd0, halted}, 32'd0);

        // 6b. reset during a stall cycle
        run_boot();
        memRead_id_ex = 1'b1; registerFileWrite_id_ex = 4'd4; rsA = 4'd4;
        reset = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("rstall_onbios", {31'd0, onBios}, 32'd1);
        check("rstall_addr", bootAddress, 32'd0);
        check("rstall_stall", {16'd0, stallCount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_sequencer
